// File: rtl/jtkunio_arb_pkg.sv
// rtl/jtkunio_arb_pkg.sv - shared types and constants for the SDRAM bank arbiter
package jtkunio_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DATA,
    ST_WRWAIT
  } arb_state_e;

  localparam logic [1:0] BA_MAIN = 2'd0;
  localparam logic [1:0] BA_SND  = 2'd1;
  localparam logic [1:0] BA_GFX  = 2'd2;
  localparam logic [1:0] BA_OBJ  = 2'd3;

  function automatic bit burst_ok(input int burst);
    return (burst >= 1) && (burst <= 4);
  endfunction

endpackage

// File: rtl/jtkunio_rr_pick.sv
// rtl/jtkunio_rr_pick.sv - 4-way round-robin picker, first request at or after ptr
module jtkunio_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       valid
);

  // Scan from the far end back to ptr so the nearest requester wins last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        gnt   = ptr + 2'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtkunio_sdram_arb.sv
// rtl/jtkunio_sdram_arb.sv - shares one SDRAM port between four ROM bank readers
// and the download writer; writes win while downloading, reads are round-robin.
module jtkunio_sdram_arb
  import jtkunio_arb_pkg::*;
#(
  parameter int BURST   = 2,
  parameter int TIMEOUT = 64,
  parameter int AW      = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  input  logic          downloading,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic          cmd_req,
  output logic          cmd_we,
  output logic [1:0]    cmd_ba,
  output logic [AW-1:0] cmd_addr,
  output logic [15:0]   cmd_din,
  output logic [1:0]    cmd_mask,
  input  logic          cmd_gnt,
  input  logic          rd_valid,
  input  logic [15:0]   rd_data,
  input  logic          wr_done,
  output logic          timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  if (!burst_ok(BURST)) begin : g_bad_burst
    $error("jtkunio_sdram_arb: BURST must be in 1..4");
  end

  arb_state_e    state;
  logic [1:0]    rr, idx, pick;
  logic          pick_vld;
  logic [1:0]    wcnt;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] sel_addr;
  logic [3:0]    idx_oh;
  logic          rd_win, last_word;

  jtkunio_rr_pick u_pick (
    .req   (ba_rd),
    .ptr   (rr),
    .gnt   (pick),
    .valid (pick_vld)
  );

  always_comb begin
    sel_addr = ba3_addr;
    case (pick)
      BA_MAIN: sel_addr = ba0_addr;
      BA_SND:  sel_addr = ba1_addr;
      BA_GFX:  sel_addr = ba2_addr;
      BA_OBJ:  sel_addr = ba3_addr;
      default: sel_addr = ba3_addr;
    endcase
  end

  // Strobes track rd_valid in the same cycle so the bank slot sees data_read with no delay.
  assign idx_oh    = 4'b0001 << idx;
  assign rd_win    = rd_valid && ((state == ST_WAIT) || (state == ST_DATA));
  assign last_word = ((state == ST_WAIT) && (BURST == 1)) ||
                     ((state == ST_DATA) && (wcnt == 2'(BURST - 1)));
  assign ba_ack    = (state == ST_ISSUE && cmd_gnt && !cmd_we) ? idx_oh : 4'b0000;
  assign ba_dok    = rd_win ? idx_oh : 4'b0000;
  assign ba_dst    = (rd_valid && state == ST_WAIT) ? idx_oh : 4'b0000;
  assign ba_rdy    = (rd_win && last_word) ? idx_oh : 4'b0000;
  assign prog_ack  = (state == ST_ISSUE) && cmd_gnt && cmd_we;
  assign prog_rdy  = (state == ST_WRWAIT) && wr_done;
  assign data_read = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr          <= 2'd0;
      idx         <= 2'd0;
      wcnt        <= 2'd0;
      tcnt        <= '0;
      cmd_req     <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_ba      <= 2'd0;
      cmd_addr    <= '0;
      cmd_din     <= 16'd0;
      cmd_mask    <= 2'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (downloading && prog_we) begin
            cmd_we   <= 1'b1;
            cmd_ba   <= prog_ba;
            cmd_addr <= prog_addr;
            cmd_din  <= prog_data;
            cmd_mask <= prog_mask;
            cmd_req  <= 1'b1;
            state    <= ST_ISSUE;
          end else if (!downloading && pick_vld) begin
            cmd_we   <= 1'b0;
            cmd_ba   <= pick;
            idx      <= pick;
            cmd_addr <= sel_addr;
            cmd_req  <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_gnt) begin
            cmd_req <= 1'b0;
            tcnt    <= TW'(TIMEOUT - 1);
            state   <= cmd_we ? ST_WRWAIT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rd_valid) begin
            if (BURST == 1) begin
              rr    <= idx + 2'd1;
              state <= ST_IDLE;
            end else begin
              wcnt  <= 2'd1;
              state <= ST_DATA;
            end
          end else if (tcnt == '0) begin
            timeout_err <= 1'b1;
            rr          <= idx + 2'd1;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        ST_DATA: begin
          if (rd_valid) begin
            if (last_word) begin
              rr    <= idx + 2'd1;
              state <= ST_IDLE;
            end else begin
              wcnt <= wcnt + 2'd1;
            end
          end
        end
        ST_WRWAIT: begin
          if (wr_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkunio_sdram_arb.sv
// tb/tb_jtkunio_sdram_arb.sv - directed self-checking bench for jtkunio_sdram_arb
module tb_jtkunio_sdram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic        downloading, prog_we;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_ack, prog_rdy;
  logic        cmd_req, cmd_we;
  logic [1:0]  cmd_ba;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_din;
  logic [1:0]  cmd_mask;
  logic        cmd_gnt, rd_valid, wr_done;
  logic [15:0] rd_data;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtkunio_sdram_arb #(.BURST(2), .TIMEOUT(64), .AW(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read), .downloading(downloading), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy), .cmd_req(cmd_req), .cmd_we(cmd_we),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_mask(cmd_mask),
    .cmd_gnt(cmd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ba_rd = 4'b0000; downloading = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_ba = 2'd0; prog_data = 16'd0; prog_mask = 2'd0;
    cmd_gnt = 1'b0; rd_valid = 1'b0; wr_done = 1'b0; rd_data = 16'hBEEF;
    ba0_addr = 22'h000F00; ba1_addr = 22'h0011AA; ba2_addr = 22'h001234; ba3_addr = 22'h3C0003;
    tick(); tick();
    tests++; if (cmd_req !== 1'b0) begin fails++; $display("FAIL reset_cmd_req: got %b want 0", cmd_req); end
    tests++; if (cmd_addr !== 22'h0 || cmd_din !== 16'h0) begin fails++; $display("FAIL reset_cmd_fields: got addr %h din %h want 0", cmd_addr, cmd_din); end
    tests++; if ({ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy, timeout_err} !== 19'h0) begin
      fails++; $display("FAIL reset_strobes: got %h want 0", {ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy, timeout_err});
    end
    tests++; if (data_read !== 16'hBEEF) begin fails++; $display("FAIL data_passthru: got %h want beef", data_read); end
    rst_n = 1'b1;
    tick();
    tests++; if (cmd_req !== 1'b0) begin fails++; $display("FAIL idle_no_req: got %b want 0", cmd_req); end
  endtask

  task automatic test_single_read();
    ba_rd = 4'b0100;
    tick();
    tests++; if (cmd_req !== 1'b1 || cmd_we !== 1'b0 || cmd_ba !== 2'd2 || cmd_addr !== 22'h001234) begin
      fails++; $display("FAIL single_issue: got req %b we %b ba %0d addr %h want 1 0 2 001234", cmd_req, cmd_we, cmd_ba, cmd_addr);
    end
    tests++; if (ba_ack !== 4'b0000) begin fails++; $display("FAIL single_early_ack: got %b want 0000", ba_ack); end
    tick();
    cmd_gnt = 1'b1; #1;
    tests++; if (ba_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", ba_ack); end
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0000;
    tests++; if (cmd_req !== 1'b0) begin fails++; $display("FAIL single_req_drop: got %b want 0", cmd_req); end
    tests++; if (ba_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_once: got %b want 0000", ba_ack); end
    rd_valid = 1'b1; rd_data = 16'hA001; #1;
    tests++; if (ba_dst !== 4'b0100 || ba_dok !== 4'b0100 || ba_rdy !== 4'b0000 || data_read !== 16'hA001) begin
      fails++; $display("FAIL single_word0: got dst %b dok %b rdy %b data %h want 0100 0100 0000 a001", ba_dst, ba_dok, ba_rdy, data_read);
    end
    tick();
    rd_data = 16'hA002; #1;
    tests++; if (ba_dst !== 4'b0000 || ba_dok !== 4'b0100 || ba_rdy !== 4'b0100) begin
      fails++; $display("FAIL single_word1: got dst %b dok %b rdy %b want 0000 0100 0100", ba_dst, ba_dok, ba_rdy);
    end
    tick();
    tests++; if (ba_dok !== 4'b0000 || ba_rdy !== 4'b0000) begin
      fails++; $display("FAIL single_after_burst: got dok %b rdy %b want 0", ba_dok, ba_rdy);
    end
    rd_valid = 1'b0;
  endtask

  // rr is 3 after the single read of bank 2, so the ring starts at bank 3.
  task automatic test_fairness();
    logic [1:0] order [5];
    int n;
    order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd1; order[3] = 2'd2; order[4] = 2'd3;
    ba_rd = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!cmd_req && n < 20) begin tick(); n++; end
      tests++; if (cmd_req !== 1'b1) begin fails++; $display("FAIL fair_req_timeout[%0d]: got %b want 1", g, cmd_req); end
      tests++; if (cmd_ba !== order[g]) begin fails++; $display("FAIL fair_order[%0d]: got %0d want %0d", g, cmd_ba, order[g]); end
      cmd_gnt = 1'b1; #1;
      tests++; if (ba_ack !== (4'b0001 << order[g])) begin fails++; $display("FAIL fair_ack[%0d]: got %b want %b", g, ba_ack, 4'b0001 << order[g]); end
      tick();
      cmd_gnt = 1'b0; rd_valid = 1'b1;
      tick();
      tick();
      rd_valid = 1'b0;
      if (g == 4) ba_rd = 4'b0000;
    end
    tick();
  endtask

  // rr is 0 here (last read was bank 3).
  task automatic test_download();
    downloading = 1'b1; prog_we = 1'b1; prog_addr = 22'h2A5A5; prog_ba = 2'd3;
    prog_data = 16'hC3C3; prog_mask = 2'b10; ba_rd = 4'b0001;
    tick();
    tests++; if (cmd_req !== 1'b1 || cmd_we !== 1'b1 || cmd_ba !== 2'd3 || cmd_addr !== 22'h2A5A5 ||
                 cmd_din !== 16'hC3C3 || cmd_mask !== 2'b10) begin
      fails++; $display("FAIL dl_issue: got req %b we %b ba %0d addr %h din %h mask %b want 1 1 3 2a5a5 c3c3 10",
                        cmd_req, cmd_we, cmd_ba, cmd_addr, cmd_din, cmd_mask);
    end
    cmd_gnt = 1'b1; #1;
    tests++; if (prog_ack !== 1'b1 || ba_ack !== 4'b0000) begin fails++; $display("FAIL dl_ack: got prog_ack %b ba_ack %b want 1 0000", prog_ack, ba_ack); end
    tick();
    cmd_gnt = 1'b0; prog_we = 1'b0;
    tick();
    tests++; if (prog_rdy !== 1'b0 || prog_ack !== 1'b0) begin fails++; $display("FAIL dl_early_rdy: got rdy %b ack %b want 0 0", prog_rdy, prog_ack); end
    wr_done = 1'b1; #1;
    tests++; if (prog_rdy !== 1'b1) begin fails++; $display("FAIL dl_rdy: got %b want 1", prog_rdy); end
    tick();
    wr_done = 1'b0;
    tick(); tick(); tick();
    tests++; if (cmd_req !== 1'b0 || ba_ack !== 4'b0000) begin fails++; $display("FAIL dl_read_blocked: got req %b ack %b want 0 0000", cmd_req, ba_ack); end
    downloading = 1'b0;
    tick();
    tests++; if (cmd_req !== 1'b1 || cmd_we !== 1'b0 || cmd_ba !== 2'd0 || cmd_addr !== 22'h000F00) begin
      fails++; $display("FAIL dl_read_resume: got req %b we %b ba %0d addr %h want 1 0 0 000f00", cmd_req, cmd_we, cmd_ba, cmd_addr);
    end
    cmd_gnt = 1'b1; #1;
    tests++; if (ba_ack !== 4'b0001) begin fails++; $display("FAIL dl_read_ack: got %b want 0001", ba_ack); end
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0000; rd_valid = 1'b1;
    tick(); tick();
    rd_valid = 1'b0;
    tick();
  endtask

  // rr is 1 here: bank 1 wins, then times out; bank 2 is served next.
  task automatic test_timeout();
    int bad;
    ba_rd = 4'b0110;
    tick();
    tests++; if (cmd_ba !== 2'd1 || cmd_req !== 1'b1) begin fails++; $display("FAIL to_grant: got ba %0d req %b want 1 1", cmd_ba, cmd_req); end
    cmd_gnt = 1'b1;
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0100;
    bad = 0;
    for (int c = 0; c < 63; c++) begin
      if (ba_rdy !== 4'b0000 || ba_dst !== 4'b0000) bad++;
      tick();
    end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b want 0 at 63 wait cycles", timeout_err); end
    tick();
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL to_no_strobe: got %0d strobe cycles want 0", bad); end
    tick();
    tests++; if (cmd_req !== 1'b1 || cmd_ba !== 2'd2 || cmd_addr !== 22'h001234) begin
      fails++; $display("FAIL to_next: got req %b ba %0d addr %h want 1 2 001234", cmd_req, cmd_ba, cmd_addr);
    end
    cmd_gnt = 1'b1;
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0000; rd_valid = 1'b1;
    tick();
    #1;
    tests++; if (ba_rdy !== 4'b0100) begin fails++; $display("FAIL to_next_rdy: got %b want 0100", ba_rdy); end
    tick();
    rd_valid = 1'b0;
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  // rr is 3 here; bank 1 is the only requester.
  task automatic test_gapped();
    int bad;
    ba_rd = 4'b0010;
    tick();
    tests++; if (cmd_ba !== 2'd1 || cmd_addr !== 22'h0011AA) begin fails++; $display("FAIL gap_grant: got ba %0d addr %h want 1 0011aa", cmd_ba, cmd_addr); end
    cmd_gnt = 1'b1;
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0000; rd_valid = 1'b1; #1;
    tests++; if (ba_dst !== 4'b0010 || ba_dok !== 4'b0010 || ba_rdy !== 4'b0000) begin
      fails++; $display("FAIL gap_word0: got dst %b dok %b rdy %b want 0010 0010 0000", ba_dst, ba_dok, ba_rdy);
    end
    tick();
    rd_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ba_dok !== 4'b0000 || ba_rdy !== 4'b0000 || ba_dst !== 4'b0000) bad++;
      tick();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL gap_idle: got %0d strobe cycles want 0", bad); end
    rd_valid = 1'b1; #1;
    tests++; if (ba_dok !== 4'b0010 || ba_rdy !== 4'b0010 || ba_dst !== 4'b0000) begin
      fails++; $display("FAIL gap_word1: got dst %b dok %b rdy %b want 0000 0010 0010", ba_dst, ba_dok, ba_rdy);
    end
    tick();
    rd_valid = 1'b0;
    tick();
  endtask

  // rr is 2 here; bank 3 wins, then reset lands mid-burst and rr must return to 0.
  task automatic test_reset_mid_burst();
    ba_rd = 4'b1000;
    tick();
    tests++; if (cmd_ba !== 2'd3) begin fails++; $display("FAIL rst_grant: got %0d want 3", cmd_ba); end
    cmd_gnt = 1'b1;
    tick();
    cmd_gnt = 1'b0; rd_valid = 1'b1; #1;
    tests++; if (ba_dok !== 4'b1000) begin fails++; $display("FAIL rst_word0: got %b want 1000", ba_dok); end
    rst_n = 1'b0; #1;
    tests++; if ({ba_dok, ba_rdy, ba_dst, cmd_req, timeout_err} !== 14'h0) begin
      fails++; $display("FAIL rst_outputs: got %h want 0", {ba_dok, ba_rdy, ba_dst, cmd_req, timeout_err});
    end
    tick();
    tests++; if (ba_rdy !== 4'b0000) begin fails++; $display("FAIL rst_no_rdy: got %b want 0000", ba_rdy); end
    rd_valid = 1'b0; ba_rd = 4'b1001;
    rst_n = 1'b1;
    tick();
    tests++; if (cmd_req !== 1'b1 || cmd_ba !== 2'd0) begin fails++; $display("FAIL rst_rr_zero: got req %b ba %0d want 1 0", cmd_req, cmd_ba); end
    cmd_gnt = 1'b1; #1;
    tests++; if (ba_ack !== 4'b0001) begin fails++; $display("FAIL rst_ack: got %b want 0001", ba_ack); end
    tick();
    cmd_gnt = 1'b0; ba_rd = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_download();
    test_timeout();
    test_gapped();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
